// File: rtl/dp_param_core.sv
// Parametrised K&S data path: IR, PC, 2R/1W register file, 8-function ALU, registered flags, RAM address mux.
// Optional build macro DP_R0_ZERO_EN hardwires register 0 to zero.
module dp_param_core #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 2,
   parameter int MEM_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              branch,
   input  logic              pc_enable,
   input  logic              ir_enable,
   input  logic              addr_sel,
   input  logic              c_sel,
   input  logic [2:0]        operation,
   input  logic              write_reg_enable,
   input  logic              flags_reg_enable,
   output logic [7:0]        opcode,
   output logic              zero_op,
   output logic              neg_op,
   output logic              unsigned_overflow,
   output logic              signed_overflow,
   output logic [MEM_AW-1:0] ram_addr,
   output logic [DATA_W-1:0] data_out,
   input  logic [DATA_W-1:0] data_in
);

   localparam int NREG = 2 ** REG_AW;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_PASS = 3'b101;
   localparam logic [2:0] OP_SHL  = 3'b110;
   localparam logic [2:0] OP_SHR  = 3'b111;

   logic [DATA_W-1:0] ir;
   logic [MEM_AW-1:0] pc;
   logic [DATA_W-1:0] regs [NREG];

   logic [REG_AW-1:0] c_addr, a_addr, b_addr;
   logic [MEM_AW-1:0] mem_addr;
   logic [DATA_W-1:0] bus_a, bus_b, bus_c, alu_out;
   logic [DATA_W:0]   sum, diff;
   logic              uov_next, sov_next;
   logic              a_msb, b_msb;

   // IR bits between the opcode and the operand fields carry no meaning here.
   logic unused_ir_bits;
   assign unused_ir_bits = ^ir;

   assign c_addr   = ir[3*REG_AW-1:2*REG_AW];
   assign a_addr   = ir[2*REG_AW-1:REG_AW];
   assign b_addr   = ir[REG_AW-1:0];
   assign mem_addr = ir[MEM_AW-1:0];
   assign opcode   = ir[DATA_W-1 -: 8];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ir <= '0;
         pc <= '0;
      end else begin
         if (ir_enable) ir <= data_in;
         // Branch target comes from the IR value before any same-cycle IR load.
         if (pc_enable) pc <= branch ? mem_addr : pc + 1'b1;
      end
   end

`ifdef DP_R0_ZERO_EN
   assign bus_a = (a_addr == '0) ? '0 : regs[a_addr];
   assign bus_b = (b_addr == '0) ? '0 : regs[b_addr];
`else
   assign bus_a = regs[a_addr];
   assign bus_b = regs[b_addr];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
`ifdef DP_R0_ZERO_EN
         if (write_reg_enable && c_addr != '0) regs[c_addr] <= bus_c;
`else
         if (write_reg_enable) regs[c_addr] <= bus_c;
`endif
      end
   end

   assign bus_c    = c_sel ? alu_out : data_in;
   assign data_out = bus_a;
   assign ram_addr = addr_sel ? pc : mem_addr;

   assign sum   = {1'b0, bus_a} + {1'b0, bus_b};
   assign diff  = {1'b0, bus_a} - {1'b0, bus_b};
   assign a_msb = bus_a[DATA_W-1];
   assign b_msb = bus_b[DATA_W-1];

   always_comb begin
      alu_out  = '0;
      uov_next = 1'b0;
      sov_next = 1'b0;
      case (operation)
         OP_ADD: begin
            alu_out  = sum[DATA_W-1:0];
            uov_next = sum[DATA_W];
            // carry into the MSB is recovered from the MSB sum bit and its operands
            sov_next = sum[DATA_W] ^ (sum[DATA_W-1] ^ a_msb ^ b_msb);
         end
         OP_SUB: begin
            alu_out  = diff[DATA_W-1:0];
            uov_next = diff[DATA_W];
            sov_next = (a_msb != b_msb) && (diff[DATA_W-1] != a_msb);
         end
         OP_AND:  alu_out = bus_a & bus_b;
         OP_OR:   alu_out = bus_a | bus_b;
         OP_XOR:  alu_out = bus_a ^ bus_b;
         OP_PASS: alu_out = bus_a;
         OP_SHL: begin
            alu_out  = {bus_a[DATA_W-2:0], 1'b0};
            uov_next = a_msb;
         end
         OP_SHR: begin
            alu_out  = {1'b0, bus_a[DATA_W-1:1]};
            uov_next = bus_a[0];
         end
         default: alu_out = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         zero_op           <= 1'b0;
         neg_op            <= 1'b0;
         unsigned_overflow <= 1'b0;
         signed_overflow   <= 1'b0;
      end else if (flags_reg_enable) begin
         zero_op           <= (alu_out == '0);
         neg_op            <= alu_out[DATA_W-1];
         unsigned_overflow <= uov_next;
         signed_overflow   <= sov_next;
      end
   end

endmodule
